// File: rtl/comm_sequencer.sv
// Top-level comm scheduler: loads N_VEC A and B operand packets from the host, starts the MAC
// engine, then streams the N_VEC result packets back out. Sole owner of comm_op/comm_start.
module comm_sequencer #(
  parameter int N_VEC    = 4,
  parameter int PKT_W    = 136,
  parameter int MAX_SIZE = 8,
  parameter int TIMEOUT  = 1000000,
  localparam int AW      = (N_VEC > 1) ? $clog2(N_VEC) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go,
  output logic             seq_busy,
  output logic             done,
  output logic             err,
  output logic             comm_op,
  output logic             comm_start,
  output logic [PKT_W-1:0] comm_tx_data,
  input  logic             comm_busy,
  input  logic             comm_rx_complete,
  input  logic             comm_tx_complete,
  input  logic [PKT_W-1:0] comm_rx_data,
  output logic             a_we,
  output logic             b_we,
  output logic [AW-1:0]    buf_addr,
  output logic [PKT_W-1:0] buf_wdata,
  output logic             mac_start,
  input  logic             mac_done,
  input  logic [PKT_W-1:0] res_rdata
);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] LA_ISSUE = 4'd1;
  localparam logic [3:0] LA_WAIT  = 4'd2;
  localparam logic [3:0] LB_ISSUE = 4'd3;
  localparam logic [3:0] LB_WAIT  = 4'd4;
  localparam logic [3:0] COMPUTE  = 4'd5;
  localparam logic [3:0] S_RD     = 4'd6;
  localparam logic [3:0] S_LAT    = 4'd7;
  localparam logic [3:0] S_ISSUE  = 4'd8;
  localparam logic [3:0] S_WAIT   = 4'd9;

  localparam logic [AW-1:0] LAST     = AW'(N_VEC - 1);
  localparam logic [7:0]    MAX_SZ   = 8'(MAX_SIZE);
  localparam logic [WW-1:0] WAIT_LIM = WW'(TIMEOUT - 1);

  logic [3:0]    state;
  logic [AW-1:0] cnt;
  logic [WW-1:0] wait_cnt;
  logic [7:0]    rx_size;
  logic          size_bad;
  logic          timed_out;
  logic          in_load_a;

  assign rx_size   = comm_rx_data[PKT_W-1 -: 8];
  assign size_bad  = (rx_size == 8'd0) || (rx_size > MAX_SZ) || rx_size[0];
  assign timed_out = (wait_cnt == WAIT_LIM);
  assign in_load_a = (state == LA_ISSUE) || (state == LA_WAIT);
  assign seq_busy  = (state != IDLE);

  // NOTE: every register here is updated with <= so all branches see the pre-edge values of
  // state/cnt (e.g. buf_addr<=cnt captures the old cnt while cnt advances in the same edge).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      wait_cnt     <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      comm_op      <= 1'b0;
      comm_start   <= 1'b0;
      comm_tx_data <= '0;
      a_we         <= 1'b0;
      b_we         <= 1'b0;
      buf_addr     <= '0;
      buf_wdata    <= '0;
      mac_start    <= 1'b0;
    end else begin
      // Strobes default low so each one lasts exactly the cycle after it is set.
      comm_start <= 1'b0;
      a_we       <= 1'b0;
      b_we       <= 1'b0;
      mac_start  <= 1'b0;
      done       <= 1'b0;
      wait_cnt   <= wait_cnt + WW'(1);

      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (go) begin
            state <= LA_ISSUE;
            err   <= 1'b0;
            cnt   <= '0;
          end
        end

        LA_ISSUE, LB_ISSUE, S_ISSUE: begin
          if (!comm_busy) begin
            comm_op    <= (state == S_ISSUE);
            comm_start <= 1'b1;
            wait_cnt   <= '0;
            state      <= (state == LA_ISSUE) ? LA_WAIT :
                          (state == LB_ISSUE) ? LB_WAIT : S_WAIT;
          end else if (timed_out) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end

        LA_WAIT, LB_WAIT: begin
          if (comm_rx_complete) begin
            wait_cnt <= '0;
            if (size_bad) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              buf_wdata <= comm_rx_data;
              buf_addr  <= cnt;
              a_we      <= in_load_a;
              b_we      <= !in_load_a;
              cnt       <= (cnt == LAST) ? '0 : cnt + AW'(1);
              if (cnt != LAST) begin
                state <= in_load_a ? LA_ISSUE : LB_ISSUE;
              end else if (in_load_a) begin
                state <= LB_ISSUE;
              end else begin
                state     <= COMPUTE;
                mac_start <= 1'b1;
              end
            end
          end else if (timed_out) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end

        COMPUTE: begin
          if (mac_done) begin
            wait_cnt <= '0;
            cnt      <= '0;
            buf_addr <= '0;
            state    <= S_RD;
          end else if (timed_out) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end

        // Result RAM has one cycle of read latency: address in S_RD, data in S_LAT.
        S_RD: begin
          wait_cnt <= '0;
          state    <= S_LAT;
        end

        S_LAT: begin
          wait_cnt     <= '0;
          comm_tx_data <= res_rdata;
          state        <= S_ISSUE;
        end

        S_WAIT: begin
          if (comm_tx_complete) begin
            wait_cnt <= '0;
            if (cnt == LAST) begin
              done  <= 1'b1;
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt      <= cnt + AW'(1);
              buf_addr <= cnt + AW'(1);
              state    <= S_RD;
            end
          end else if (timed_out) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comm_sequencer.sv
// Bench for comm_sequencer: plays the host comm unit, result RAM and MAC engine, and checks
// each sequence against a packet-level model of what must be written, started and sent.
module tb_comm_sequencer;
  localparam int N_VEC    = 4;
  localparam int PKT_W    = 136;
  localparam int MAX_SIZE = 8;
  localparam int TIMEOUT  = 64;
  localparam int AW       = $clog2(N_VEC);

  typedef logic [PKT_W-1:0] pkt_t;
  typedef struct { logic [AW-1:0] addr; pkt_t data; } wr_t;
  typedef struct { logic [7:0] size; bit exp_err; } size_vec_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          go;
  logic          go_main = 1'b0;
  logic          go_stray = 1'b0;
  logic          seq_busy, done, err, comm_op, comm_start;
  pkt_t          comm_tx_data;
  logic          comm_busy = 1'b0;
  logic          comm_rx_complete = 1'b0;
  logic          comm_tx_complete = 1'b0;
  pkt_t          comm_rx_data = '0;
  logic          a_we, b_we;
  logic [AW-1:0] buf_addr;
  pkt_t          buf_wdata;
  logic          mac_start;
  logic          mac_done = 1'b0;
  pkt_t          res_rdata = '0;

  assign go = go_main | go_stray;

  comm_sequencer #(
    .N_VEC(N_VEC), .PKT_W(PKT_W), .MAX_SIZE(MAX_SIZE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn), .go(go), .seq_busy(seq_busy), .done(done), .err(err),
    .comm_op(comm_op), .comm_start(comm_start), .comm_tx_data(comm_tx_data),
    .comm_busy(comm_busy), .comm_rx_complete(comm_rx_complete),
    .comm_tx_complete(comm_tx_complete), .comm_rx_data(comm_rx_data),
    .a_we(a_we), .b_we(b_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .mac_start(mac_start), .mac_done(mac_done), .res_rdata(res_rdata)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input pkt_t act, input pkt_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Observed activity of the current sequence.
  wr_t  a_log[$];
  wr_t  b_log[$];
  bit   start_log[$];
  pkt_t tx_log[$];
  int   mac_cnt  = 0;
  int   done_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (a_we) a_log.push_back('{buf_addr, buf_wdata});
    if (b_we) b_log.push_back('{buf_addr, buf_wdata});
    if (comm_start) begin
      start_log.push_back(comm_op);
      if (comm_op) tx_log.push_back(comm_tx_data);
    end
    if (mac_start) mac_cnt++;
    if (done) done_cnt++;
  end

  // Result RAM: data for the address seen in one cycle appears during the next.
  pkt_t          res_mem[N_VEC];
  logic [AW-1:0] addr_d = '0;
  initial forever begin
    @(negedge clk);
    res_rdata = res_mem[addr_d];
    addr_d    = buf_addr;
  end

  // Comm unit and MAC responders.
  pkt_t rx_q[$];
  bit   hold_busy = 1'b0;
  bit   stray_en  = 1'b0;
  bit   pend = 1'b0, pend_op = 1'b0, mac_pend = 1'b0;
  int   pend_delay = 0, mac_delay = 0;
  pkt_t tx_hold = '0;

  initial forever begin
    @(negedge clk);
    comm_rx_complete = 1'b0;
    comm_tx_complete = 1'b0;
    go_stray         = 1'b0;
    mac_done         = 1'b0;
    if (!resetn) begin
      pend      = 1'b0;
      mac_pend  = 1'b0;
      comm_busy = 1'b0;
      continue;
    end
    if (pend) begin
      if (pend_delay == 0) begin
        pend      = 1'b0;
        comm_busy = hold_busy;
        if (pend_op) begin
          check("tx_data_stable", comm_tx_data, tx_hold);
          comm_tx_complete = 1'b1;
        end else begin
          comm_rx_data     = (rx_q.size() > 0) ? rx_q.pop_front() : '0;
          comm_rx_complete = 1'b1;
        end
      end else begin
        pend_delay--;
      end
    end else if (comm_start) begin
      pend       = 1'b1;
      pend_op    = comm_op;
      pend_delay = $urandom_range(0, 3);
      comm_busy  = 1'b1;
      tx_hold    = comm_tx_data;
    end else begin
      comm_busy = hold_busy;
      if (stray_en && $urandom_range(0, 4) == 0) begin
        if (mac_cnt == 0) comm_tx_complete = 1'b1;
        else begin
          comm_rx_data     = '0;
          comm_rx_complete = 1'b1;
        end
      end
    end
    if (stray_en && seq_busy && $urandom_range(0, 6) == 0) go_stray = 1'b1;
    if (mac_pend) begin
      if (mac_delay == 0) begin
        mac_pend = 1'b0;
        mac_done = 1'b1;
      end else begin
        mac_delay--;
      end
    end else if (mac_start) begin
      mac_pend  = 1'b1;
      mac_delay = $urandom_range(0, 5);
    end
  end

  pkt_t stim[2*N_VEC];

  function automatic logic [7:0] legal_size();
    return 8'(2 * $urandom_range(1, MAX_SIZE / 2));
  endfunction

  function automatic logic [7:0] bad_size();
    case ($urandom_range(0, 2))
      0:       return 8'd0;
      1:       return 8'(2 * $urandom_range(0, 3) + 1);
      default: return 8'($urandom_range(MAX_SIZE + 1, 255));
    endcase
  endfunction

  task automatic fill_legal();
    for (int i = 0; i < 2*N_VEC; i++)
      stim[i] = {legal_size(), $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic start_seq();
    a_log.delete(); b_log.delete(); start_log.delete(); tx_log.delete();
    rx_q.delete();
    mac_cnt  = 0;
    done_cnt = 0;
    for (int i = 0; i < 2*N_VEC; i++) rx_q.push_back(stim[i]);
    go_main = 1'b1;
    @(negedge clk);
    go_main = 1'b0;
  endtask

  // Packet-level model: packets are consumed in order, the first N_VEC fill A and the next
  // N_VEC fill B; the first illegal size aborts with err. A clean load is followed by one MAC
  // start, N_VEC transmissions of the result RAM in address order, and one done.
  task automatic run_seq(input string name);
    pkt_t       exp_a[$];
    pkt_t       exp_b[$];
    bit         exp_err = 1'b0;
    int         used = 0;
    int         rx_starts = 0;
    int         tx_starts = 0;
    logic [7:0] sz;
    for (int i = 0; i < 2*N_VEC; i++) begin
      sz = stim[i][PKT_W-1 -: 8];
      used++;
      if (sz == 0 || sz > MAX_SIZE || sz % 2 == 1) begin
        exp_err = 1'b1;
        break;
      end
      if (i < N_VEC) exp_a.push_back(stim[i]);
      else           exp_b.push_back(stim[i]);
    end

    start_seq();
    check({name, "/busy_after_go"}, seq_busy, 1);
    check({name, "/err_cleared"}, err, 0);
    for (int c = 0; c < 3000 && seq_busy; c++) @(negedge clk);
    check({name, "/returned_idle"}, seq_busy, 0);
    repeat (2) @(negedge clk);

    check({name, "/err"}, err, exp_err);
    check({name, "/a_writes"}, a_log.size(), exp_a.size());
    for (int k = 0; k < a_log.size() && k < exp_a.size(); k++) begin
      check({name, "/a_addr"}, a_log[k].addr, k);
      check({name, "/a_data"}, a_log[k].data, exp_a[k]);
    end
    check({name, "/b_writes"}, b_log.size(), exp_b.size());
    for (int k = 0; k < b_log.size() && k < exp_b.size(); k++) begin
      check({name, "/b_addr"}, b_log[k].addr, k);
      check({name, "/b_data"}, b_log[k].data, exp_b[k]);
    end
    foreach (start_log[k]) begin
      if (start_log[k]) tx_starts++;
      else              rx_starts++;
    end
    check({name, "/rx_starts"}, rx_starts, used);
    check({name, "/tx_starts"}, tx_starts, exp_err ? 0 : N_VEC);
    for (int k = 0; k < tx_log.size() && k < N_VEC; k++)
      check({name, "/tx_data"}, tx_log[k], res_mem[k]);
    check({name, "/mac_starts"}, mac_cnt, exp_err ? 0 : 1);
    check({name, "/done_pulses"}, done_cnt, exp_err ? 0 : 1);
  endtask

  size_vec_t svec[11];

  initial begin
    svec = '{'{8'd0, 1'b1}, '{8'd1, 1'b1}, '{8'd2, 1'b0}, '{8'd3, 1'b1},
             '{8'd4, 1'b0}, '{8'd6, 1'b0}, '{8'd7, 1'b1}, '{8'd8, 1'b0},
             '{8'd9, 1'b1}, '{8'd10, 1'b1}, '{8'd255, 1'b1}};
    for (int a = 0; a < N_VEC; a++)
      res_mem[a] = {8'd8, 64'h74FB7BFE978F83D7 ^ 64'(a), 16'd0, 16'd1, 16'd2, 16'd3};

    repeat (3) @(negedge clk);
    check("reset_ctrl", {seq_busy, done, err, comm_op, comm_start, a_we, b_we, mac_start, buf_addr}, 0);
    check("reset_wdata", buf_wdata, 0);
    check("reset_txdata", comm_tx_data, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Fixed operand packets with address-tagged results.
    for (int i = 0; i < 2*N_VEC; i++)
      stim[i] = {8'd4, 32'h74FB7BFE, 32'h0, 16'd0, 16'd3, 32'h0};
    run_seq("basic");

    // Size-byte legality table, applied to the first A packet.
    for (int t = 0; t < 11; t++) begin
      fill_legal();
      stim[0][PKT_W-1 -: 8] = svec[t].size;
      run_seq($sformatf("size_%0d", svec[t].size));
      check($sformatf("size_%0d/table_err", svec[t].size), err, svec[t].exp_err);
      check($sformatf("size_%0d/table_a", svec[t].size), a_log.size(), svec[t].exp_err ? 0 : N_VEC);
    end

    // Illegal size in the B phase.
    fill_legal();
    stim[N_VEC + 1][PKT_W-1 -: 8] = 8'd9;
    run_seq("bad_b");

    // comm_busy stuck high: the first ISSUE must time out without a start.
    hold_busy = 1'b1;
    start_seq();
    repeat (50) @(negedge clk);
    check("timeout/still_waiting", seq_busy, 1);
    repeat (20) @(negedge clk);
    check("timeout/idle", seq_busy, 0);
    check("timeout/err", err, 1);
    check("timeout/no_start", start_log.size(), 0);
    hold_busy = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of LOAD_B.
    fill_legal();
    start_seq();
    for (int c = 0; c < 1000 && b_log.size() < 2; c++) @(negedge clk);
    check("midreset/b_writes_before", b_log.size(), 2);
    #2 resetn = 1'b0;
    #1;
    check("midreset/ctrl", {seq_busy, done, err, comm_op, comm_start, a_we, b_we, mac_start, buf_addr}, 0);
    check("midreset/wdata", buf_wdata, 0);
    check("midreset/txdata", comm_tx_data, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset/no_more_writes", a_log.size() + b_log.size(), N_VEC + 2);
    fill_legal();
    run_seq("after_reset");

    // Stray go pulses and stray completions must not disturb a sequence.
    stray_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      fill_legal();
      run_seq($sformatf("stray_%0d", r));
    end
    stray_en = 1'b0;
    repeat (2) @(negedge clk);

    // Randomised packets, result contents and an occasional illegal size anywhere.
    for (int r = 0; r < 15; r++) begin
      fill_legal();
      for (int a = 0; a < N_VEC; a++)
        res_mem[a] = {legal_size(), $urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0)
        stim[$urandom_range(0, 2*N_VEC - 1)][PKT_W-1 -: 8] = bad_size();
      run_seq($sformatf("rand_%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1);
  end

endmodule
